// File: rtl/relu_layer_sequencer_pkg.sv
// relu_layer_sequencer_pkg: shared FSM encodings and index-width helper for the ReLU sequencer
package relu_layer_sequencer_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/relu_layer_sequencer_relu.sv
// relu_layer_sequencer_relu: combinational ReLU, negative values clamp to zero
module relu_layer_sequencer_relu #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  output logic [N-1:0] y
);
  assign y = x[N-1] ? '0 : x;
endmodule

// File: rtl/relu_layer_sequencer.sv
// relu_layer_sequencer: streams one vector through a single shared ReLU unit, one element per cycle
module relu_layer_sequencer
  import relu_layer_sequencer_pkg::*;
#(
  parameter int N           = 8,
  parameter int NUM_NEURONS = 4,
  parameter int IDX_W       = clog2_min1(NUM_NEURONS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*NUM_NEURONS-1:0] in_vec,
  input  logic                     bypass,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N*NUM_NEURONS-1:0] out_vec,
  output logic [IDX_W:0]           nz_count,
  output logic                     busy
);
  logic [1:0]               state;
  logic [IDX_W-1:0]         index;
  logic [N*NUM_NEURONS-1:0] src, dst;
  logic                     bypass_q;
  logic [N-1:0]             cur, relu_y, wr_val;
  logic                     last;
  assign cur       = src[index*N +: N];
  assign wr_val    = bypass_q ? cur : relu_y;
  assign last      = index == IDX_W'(NUM_NEURONS - 1);
  assign in_ready  = state == ST_IDLE;
  assign out_valid = state == ST_DONE;
  assign busy      = state == ST_RUN || state == ST_DONE;
  assign out_vec   = dst;
  relu_layer_sequencer_relu #(.N(N)) u_relu (.x(cur), .y(relu_y));
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      index    <= '0;
      src      <= '0;
      dst      <= '0;
      bypass_q <= 1'b0;
      nz_count <= '0;
    end else if (state == ST_IDLE) begin
      if (in_valid) begin
        src      <= in_vec;
        bypass_q <= bypass;
        index    <= '0;
        nz_count <= '0;
        state    <= ST_RUN;
      end
    end else if (state == ST_RUN) begin
      dst[index*N +: N] <= wr_val;
      nz_count          <= nz_count + (IDX_W+1)'(|wr_val);
      index             <= last ? '0 : index + 1'b1;
      state             <= last ? ST_DONE : ST_RUN;
    end else if (state != ST_DONE || out_ready) begin
      state <= ST_IDLE;
    end
  end
endmodule
